// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with mid-bit sampling; define UART_RX_STOP_CHECK_EN to sample and validate the stop bit.
module uart_rx_core #(
  parameter int BAUD_CNT_END = 56,
  parameter int BAUD_CNT_W = 16
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       po_flag
);
`ifdef UART_RX_STOP_CHECK_EN
  localparam logic [3:0] LAST_BIT = 4'd9;
`else
  localparam logic [3:0] LAST_BIT = 4'd8;
`endif
  localparam logic [BAUD_CNT_W-1:0] MID = BAUD_CNT_W'(BAUD_CNT_END / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] WRAP = BAUD_CNT_W'(BAUD_CNT_END - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic r1, r2, r3;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic rx_flag, bit_flag, fall, ok, done;
  assign rx_flag = state == BUSY;
  assign fall = r3 & ~r2;
  assign bit_flag = rx_flag & (baud_cnt == MID);
`ifdef UART_RX_STOP_CHECK_EN
  assign ok = r2;
`else
  assign ok = 1'b1;
`endif
  always_comb begin
    state_nxt = state;
    if (!rx_flag && fall) state_nxt = BUSY;
    else if (bit_flag && ((bit_cnt == 4'd0 && r2) || bit_cnt == LAST_BIT)) state_nxt = IDLE;
  end
  // done delays the output by one cycle so rx_data and po_flag update together
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      {r3, r2, r1} <= 3'b111;
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      done <= 1'b0;
      rx_data <= '0;
      po_flag <= 1'b0;
    end else begin
      {r3, r2, r1} <= {r2, r1, rs232_rx};
      state <= state_nxt;
      baud_cnt <= (!rx_flag || baud_cnt == WRAP) ? '0 : baud_cnt + 1'b1;
      bit_cnt <= !rx_flag ? '0 : bit_cnt + 4'(bit_flag);
      if (bit_flag && bit_cnt != 4'd0 && bit_cnt <= 4'd8) shift[3'(bit_cnt - 4'd1)] <= r2;
      done <= bit_flag && bit_cnt == LAST_BIT && ok;
      po_flag <= done;
      if (done) rx_data <= shift;
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frame stimulus checked against an expected strobe list (time, byte).
module tb_uart_rx_core;
  localparam int BAUD = 56;
`ifdef UART_RX_STOP_CHECK_EN
  localparam int LAT = 3 + 9 * BAUD + BAUD / 2;
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam int LAT = 3 + 8 * BAUD + BAUD / 2;
  localparam bit STOP_CHECK = 1'b0;
`endif
  logic sclk = 1'b0, s_rst = 1'b1, rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic po_flag;
  int cyc = 0, checks = 0, errors = 0;
  int got_t[$], exp_t[$];
  logic [7:0] got_d[$], exp_d[$];
  uart_rx_core #(.BAUD_CNT_END(BAUD), .BAUD_CNT_W(16)) dut (
    .sclk(sclk), .s_rst(s_rst), .rs232_rx(rs232_rx), .rx_data(rx_data), .po_flag(po_flag)
  );
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;
  always @(negedge sclk) if (po_flag === 1'b1) begin
    got_t.push_back(cyc);
    got_d.push_back(rx_data);
  end
  task automatic hold(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(posedge sclk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    if (!STOP_CHECK || stop) begin
      exp_t.push_back(cyc + 1 + LAT);
      exp_d.push_back(b);
    end
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(b[i], BAUD);
    hold(stop, BAUD);
  endtask
  task automatic clear_q;
    got_t.delete(); got_d.delete(); exp_t.delete(); exp_d.delete();
  endtask
  task automatic test_reset;
    rs232_rx = 1'b1;
    s_rst = 1'b1;
    repeat (10) @(posedge sclk);
    #1 s_rst = 1'b0;
    hold(1'b1, 100);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset rx_data: got %h expected 00", rx_data); end
    checks++;
    if (po_flag !== 1'b0) begin errors++; $display("FAIL reset po_flag: got %b expected 0", po_flag); end
    checks++;
    if (got_d.size() !== 0) begin errors++; $display("FAIL reset strobes: got %0d expected 0", got_d.size()); end
    clear_q();
  endtask
  task automatic test_single;
    send(8'h55, 1'b1);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 1) begin errors++; $display("FAIL single count: got %0d expected 1", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL single time: got %0d expected %0d", got_t[i], exp_t[i]); end
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL single data: got %h expected %h", got_d[i], exp_d[i]); end
    end
    checks++;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL single hold: got %h expected 55", rx_data); end
    clear_q();
  endtask
  task automatic test_back_to_back;
    logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'hA5, 8'hFF};
    for (int i = 0; i < 4; i++) send(bytes[i], 1'b1);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 4) begin errors++; $display("FAIL b2b count: got %0d expected 4", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL b2b time[%0d]: got %0d expected %0d", i, got_t[i], exp_t[i]); end
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL b2b data[%0d]: got %h expected %h", i, got_d[i], exp_d[i]); end
    end
    clear_q();
  endtask
  task automatic test_glitch;
    hold(1'b0, 20);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 0) begin errors++; $display("FAIL glitch strobe: got %0d expected 0", got_d.size()); end
    send(8'h3C, 1'b1);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 1) begin errors++; $display("FAIL glitch count: got %0d expected 1", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL glitch time: got %0d expected %0d", got_t[i], exp_t[i]); end
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL glitch data: got %h expected %h", got_d[i], exp_d[i]); end
    end
    clear_q();
  endtask
  task automatic test_reset_mid;
    logic [7:0] b = 8'hC3;
    hold(1'b0, BAUD);
    for (int i = 0; i < 4; i++) hold(b[i], BAUD);
    rs232_rx = 1'b1;
    s_rst = 1'b1;
    repeat (2) @(posedge sclk);
    #1 s_rst = 1'b0;
    hold(1'b1, 600);
    checks++;
    if (got_d.size() !== 0) begin errors++; $display("FAIL rstmid strobe: got %0d expected 0", got_d.size()); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid rx_data: got %h expected 00", rx_data); end
    send(8'h81, 1'b1);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 1) begin errors++; $display("FAIL rstmid count: got %0d expected 1", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL rstmid time: got %0d expected %0d", got_t[i], exp_t[i]); end
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL rstmid data: got %h expected %h", got_d[i], exp_d[i]); end
    end
    clear_q();
  endtask
  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      send(8'($urandom), 1'b1);
      if ($urandom_range(0, 2) != 0) hold(1'b1, $urandom_range(1, 150));
    end
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL random count: got %0d expected %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL random time[%0d]: got %0d expected %0d", i, got_t[i], exp_t[i]); end
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL random data[%0d]: got %h expected %h", i, got_d[i], exp_d[i]); end
    end
    clear_q();
  endtask
`ifdef UART_RX_STOP_CHECK_EN
  task automatic test_stop_check;
    send(8'h7E, 1'b0);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 0) begin errors++; $display("FAIL stop_err strobe: got %0d expected 0", got_d.size()); end
    send(8'h7E, 1'b1);
    hold(1'b1, 200);
    checks++;
    if (got_d.size() !== 1) begin errors++; $display("FAIL stop_ok count: got %0d expected 1", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_t[i] !== exp_t[i]) begin errors++; $display("FAIL stop_ok time: got %0d expected %0d", got_t[i], exp_t[i]); end
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL stop_ok data: got %h expected %h", got_d[i], exp_d[i]); end
    end
    clear_q();
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_random();
`ifdef UART_RX_STOP_CHECK_EN
    test_stop_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receiver for 8N1 async UART frames on a single sclk domain.
- Synchronises the line, detects the start bit and samples each bit at mid-period.
- Emits each assembled byte with a one-cycle po_flag strobe.
- Sits between the board RS-232 pin and byte-level consumers (FIFO, command parser).

Parameters:
- BAUD_CNT_END, 56: sclk cycles per bit. 56 at 100 MHz gives a 560 ns bit. Legal values are 4 to 65535.
- BAUD_CNT_W, 16: width of the baud counter.

Ports:
- sclk  input  1  system clock; everything is on the rising edge.
- s_rst  input  1  synchronous active-high reset.
- rs232_rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last received byte, LSB received first.
- po_flag  output  1  one-cycle strobe; rx_data is valid in the same cycle.

Behaviour:
- Clock and reset: one clock, sclk. Reset s_rst is synchronous and active-high.
- Reset values:
  - rx_data = 0x00, po_flag = 0.
  - Internal busy flag rx_flag = 0, counters = 0.
  - Synchroniser flops = 1, so the line reads as idle.
- Synchroniser: rs232_rx feeds r1 -> r2 -> r3 every cycle. Falling edge = r3 & ~r2.
- IDLE (rx_flag = 0): a falling edge sets rx_flag = 1 and clears baud_cnt and bit_cnt on the next edge. Edges seen while busy are ignored.
- baud_cnt:
  - Increments every cycle while rx_flag = 1.
  - Wraps to 0 after BAUD_CNT_END-1.
  - Held at 0 when idle.
- bit_flag = rx_flag & (baud_cnt == BAUD_CNT_END/2 - 1), i.e. mid-bit. This is the only sampling instant, and it samples r2.
- bit_cnt increments on each bit_flag. Values: 0 = start bit, 1..8 = data bits D0..D7.
- Start validation: if r2 = 1 at the bit_cnt = 0 sample, the start is false. Set rx_flag = 0 and return to IDLE; no strobe, rx_data unchanged.
- Data: at bit_cnt = k (1..8) the sample goes into bit k-1 of the shift register.
- Completion (default build): on the bit_flag with bit_cnt = 8:
  - rx_flag <= 0.
  - Next cycle: rx_data <= full byte and po_flag = 1 for exactly one cycle.
  - The stop bit is not waited for. The receiver is back in IDLE mid-D7, ready for the next start edge.
- Timing: po_flag rises exactly 3 + 8*BAUD_CNT_END + BAUD_CNT_END/2 sclk cycles after the first cycle rs232_rx is low. That is 479 cycles at the default.
- rx_data holds its value between strobes.
- Back-to-back frames (stop bit immediately followed by the next start bit) are all received without loss.
- Reset mid-frame: the frame is abandoned, outputs return to reset values, and no strobe is produced. The next falling edge after reset starts a fresh frame.
- Line held low permanently: one false start or one byte, then no further edges, so no further strobes.

Optional Feature:
- Macro: UART_RX_STOP_CHECK_EN.
- When defined:
  - The receiver also samples the stop bit at bit_cnt = 9 and returns to IDLE there.
  - po_flag and the rx_data update occur on the cycle after that sample, and only if the stop sample = 1.
  - A stop sample of 0 (framing error) drops the byte silently: no strobe, rx_data unchanged.
  - Strobe latency becomes 3 + 9*BAUD_CNT_END + BAUD_CNT_END/2 cycles.
- When undefined: default behaviour as above.

Test Plan:
- Reset: hold s_rst high for 10 cycles with the line high, then release and idle for 100 cycles -> rx_data = 0x00, po_flag never asserts.
- Single byte 0x55 at 560 ns per bit (start, LSB first, stop) -> exactly one po_flag pulse, 479 cycles after the start edge, with rx_data = 0x55.
- Four bytes back-to-back (0x12, 0x34, 0xA5, 0xFF), no idle gap between frames -> four strobes 560 cycles apart, in order, data exact.
- Glitch: a low pulse of 20 cycles with the line otherwise high -> no po_flag; a following valid 0x3C is still received correctly.
- Reset mid-frame: assert s_rst for 2 cycles after D3 of 0xC3 -> no strobe, rx_data = 0x00; the following 0x81 frame is received correctly.
- With UART_RX_STOP_CHECK_EN: frame 0x7E with stop bit = 0 -> no strobe. A valid 0x7E then strobes 535 cycles after its start edge.
